// File: rtl/merge_stream_rx.sv
// Receiver for the 1-bit merged tracker event stream: frames events, checks the
// x^6+x+1 CRC and emits typed 12-bit words. Event-number checking is built only when
// MERGE_RX_SEQCHK_EN is defined.
module merge_stream_rx #(
  parameter int MAX_CHIPS = 6,
  parameter int ADDR_CHK  = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        DataIn,
  input  logic [3:0]  ExpAddr,
  output logic [11:0] WordOut,
  output logic [1:0]  WordType,
  output logic        WordValid,
  output logic [3:0]  BrdAddr,
  output logic        EvtDone,
  output logic        CrcErr,
  output logic        FrameErr,
  output logic        SeqErr,
  output logic [15:0] EvtCnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_SB2, S_ADDR, S_HDR, S_CHPH, S_CLUS, S_CRC, S_DONE
  } state_e;

  localparam logic [3:0] MAX_CHIPS_L = 4'(MAX_CHIPS);
  localparam logic [1:0] TYPE_EVT  = 2'd0;
  localparam logic [1:0] TYPE_CHIP = 2'd1;
  localparam logic [1:0] TYPE_CLUS = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  chip_cnt_q, chip_cnt_d;
  logic [4:0]  clus_cnt_q, clus_cnt_d;
  logic [10:0] shift_q, shift_d;
  logic [5:0]  crc_q, crc_d;
  logic [11:0] word_out_q, word_out_d;
  logic [1:0]  word_type_q, word_type_d;
  logic        word_valid_q, word_valid_d;
  logic [3:0]  brd_addr_q, brd_addr_d;
  logic        evt_done_q, evt_done_d;
  logic        crc_err_q, crc_err_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] evt_cnt_q, evt_cnt_d;
`ifdef MERGE_RX_SEQCHK_EN
  logic [4:0]  evt_num_q, evt_num_d;
  logic [4:0]  seq_ref_q, seq_ref_d;
  logic        seq_valid_q, seq_valid_d;
  logic        seq_err_q, seq_err_d;
`endif

  logic [11:0] word_full;
  logic        word_last;
  logic        crc_bad;
  logic [5:0]  crc_next;

  function automatic logic [5:0] crc_step(input logic [5:0] c, input logic b);
    logic fb;
    fb = c[5] ^ b;
    return {c[4:0], 1'b0} ^ {4'b0000, fb, fb};
  endfunction

  // The word being completed this cycle is the 11 stored bits plus the live input bit.
  assign word_full = {shift_q, DataIn};
  assign word_last = (bit_cnt_q == 4'd11);
  assign crc_bad   = (word_full[5:0] != crc_q);
  assign crc_next  = crc_step(crc_q, DataIn);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    chip_cnt_d   = chip_cnt_q;
    clus_cnt_d   = clus_cnt_q;
    shift_d      = {shift_q[9:0], DataIn};
    crc_d        = crc_q;
    word_out_d   = word_out_q;
    word_type_d  = word_type_q;
    word_valid_d = 1'b0;
    brd_addr_d   = brd_addr_q;
    evt_done_d   = 1'b0;
    crc_err_d    = 1'b0;
    frame_err_d  = 1'b0;
    evt_cnt_d    = evt_cnt_q;
`ifdef MERGE_RX_SEQCHK_EN
    evt_num_d    = evt_num_q;
    seq_ref_d    = seq_ref_q;
    seq_valid_d  = seq_valid_q;
    seq_err_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = 4'd0;
        crc_d     = 6'd0;
        if (DataIn) begin
          crc_d   = crc_step(6'd0, 1'b1);
          state_d = S_SB2;
        end
      end

      S_SB2: begin
        bit_cnt_d = 4'd0;
        if (DataIn) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          crc_d   = crc_next;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        crc_d     = crc_next;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd3) begin
          bit_cnt_d  = 4'd0;
          brd_addr_d = word_full[3:0];
          if ((ADDR_CHK != 0) && (word_full[3:0] != ExpAddr)) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_HDR;
          end
        end
      end

      S_HDR: begin
        crc_d     = crc_next;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (word_last) begin
          bit_cnt_d = 4'd0;
          if (word_full[3:0] > MAX_CHIPS_L) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            word_out_d   = word_full;
            word_type_d  = TYPE_EVT;
            word_valid_d = 1'b1;
            chip_cnt_d   = word_full[2:0];
`ifdef MERGE_RX_SEQCHK_EN
            evt_num_d    = word_full[11:7];
`endif
            state_d      = (word_full[3:0] == 4'd0) ? S_CRC : S_CHPH;
          end
        end
      end

      // The chip counter is consumed here, so zero at the end of a cluster run means no chips remain.
      S_CHPH: begin
        crc_d     = crc_next;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (word_last) begin
          bit_cnt_d = 4'd0;
          if (word_full[10:6] == 5'd0) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            word_out_d   = word_full;
            word_type_d  = TYPE_CHIP;
            word_valid_d = 1'b1;
            clus_cnt_d   = word_full[10:6];
            chip_cnt_d   = chip_cnt_q - 3'd1;
            state_d      = S_CLUS;
          end
        end
      end

      S_CLUS: begin
        crc_d     = crc_next;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (word_last) begin
          bit_cnt_d    = 4'd0;
          word_out_d   = word_full;
          word_type_d  = TYPE_CLUS;
          word_valid_d = 1'b1;
          clus_cnt_d   = clus_cnt_q - 5'd1;
          if (clus_cnt_q == 5'd1) begin
            state_d = (chip_cnt_q == 3'd0) ? S_CRC : S_CHPH;
          end
        end
      end

      S_CRC: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd5) begin
          bit_cnt_d  = 4'd0;
          evt_done_d = 1'b1;
          evt_cnt_d  = evt_cnt_q + 16'd1;
          crc_err_d  = crc_bad;
`ifdef MERGE_RX_SEQCHK_EN
          // A frame with a bad CRC neither flags nor moves the reference number.
          if (!crc_bad) begin
            seq_err_d   = seq_valid_q && (evt_num_q != (seq_ref_q + 5'd1));
            seq_ref_d   = evt_num_q;
            seq_valid_d = 1'b1;
          end
`endif
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        bit_cnt_d = 4'd0;
        crc_d     = 6'd0;
        state_d   = S_IDLE;
      end

      default: begin
        bit_cnt_d = 4'd0;
        crc_d     = 6'd0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 4'd0;
      chip_cnt_q   <= 3'd0;
      clus_cnt_q   <= 5'd0;
      shift_q      <= 11'd0;
      crc_q        <= 6'd0;
      word_out_q   <= 12'd0;
      word_type_q  <= 2'd0;
      word_valid_q <= 1'b0;
      brd_addr_q   <= 4'd0;
      evt_done_q   <= 1'b0;
      crc_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      evt_cnt_q    <= 16'd0;
`ifdef MERGE_RX_SEQCHK_EN
      evt_num_q    <= 5'd0;
      seq_ref_q    <= 5'd0;
      seq_valid_q  <= 1'b0;
      seq_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      chip_cnt_q   <= chip_cnt_d;
      clus_cnt_q   <= clus_cnt_d;
      shift_q      <= shift_d;
      crc_q        <= crc_d;
      word_out_q   <= word_out_d;
      word_type_q  <= word_type_d;
      word_valid_q <= word_valid_d;
      brd_addr_q   <= brd_addr_d;
      evt_done_q   <= evt_done_d;
      crc_err_q    <= crc_err_d;
      frame_err_q  <= frame_err_d;
      evt_cnt_q    <= evt_cnt_d;
`ifdef MERGE_RX_SEQCHK_EN
      evt_num_q    <= evt_num_d;
      seq_ref_q    <= seq_ref_d;
      seq_valid_q  <= seq_valid_d;
      seq_err_q    <= seq_err_d;
`endif
    end
  end

  assign WordOut   = word_out_q;
  assign WordType  = word_type_q;
  assign WordValid = word_valid_q;
  assign BrdAddr   = brd_addr_q;
  assign EvtDone   = evt_done_q;
  assign CrcErr    = crc_err_q;
  assign FrameErr  = frame_err_q;
  assign EvtCnt    = evt_cnt_q;
`ifdef MERGE_RX_SEQCHK_EN
  assign SeqErr    = seq_err_q;
`else
  assign SeqErr    = 1'b0;
`endif

endmodule

// File: tb/tb_merge_stream_rx.sv
// Self-checking bench for merge_stream_rx: table of frames with optional error/reset
// preambles, plus a word scoreboard filled as the stream is driven.
module tb_merge_stream_rx;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        DataIn = 1'b0;
  logic [3:0]  ExpAddr = 4'h3;
  logic [11:0] WordOut;
  logic [1:0]  WordType;
  logic        WordValid;
  logic [3:0]  BrdAddr;
  logic        EvtDone;
  logic        CrcErr;
  logic        FrameErr;
  logic        SeqErr;
  logic [15:0] EvtCnt;

  merge_stream_rx dut (
    .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .ExpAddr(ExpAddr),
    .WordOut(WordOut), .WordType(WordType), .WordValid(WordValid),
    .BrdAddr(BrdAddr), .EvtDone(EvtDone), .CrcErr(CrcErr),
    .FrameErr(FrameErr), .SeqErr(SeqErr), .EvtCnt(EvtCnt)
  );

  always #5 Clock = ~Clock;

  typedef struct { logic [11:0] w; logic [1:0] t; } exp_word_t;
  typedef struct { int end_idx; logic [11:0] w; logic [1:0] t; } pend_t;
  typedef struct {
    int               pre;
    logic [3:0]       addr;
    logic [4:0]       evt;
    logic [3:0]       nchips;
    logic [5:0][4:0]  nclus;
    bit               flip;
    bit               exp_crc;
    bit               exp_seq;
  } vec_t;

  exp_word_t   sb_q[$];
  pend_t       pend_q[$];
  bit          frame_bits[$];
  vec_t        vecs[$];
  exp_word_t   mon_e;

  int          checks = 0;
  int          passes = 0;
  int          cycle = 0;
  int          last_word_cycle = -1;
  int          done_cnt = 0;
  int          ferr_cnt = 0;
  logic        cap_crc = 1'b0;
  logic        cap_seq = 1'b0;
  logic [15:0] cap_cnt = 16'd0;
  logic [15:0] exp_evtcnt = 16'd0;

  always @(posedge Clock) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Output monitor: pops expected words and captures the end-of-event status.
  always @(negedge Clock) begin
    if (Reset) begin
      if (WordValid) begin
        checkOutput("word queued", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          checkOutput("word data", WordOut, mon_e.w);
          checkOutput("word type", WordType, mon_e.t);
        end
        if (last_word_cycle >= 0) checkOutput("word spacing", cycle - last_word_cycle, 12);
        last_word_cycle = cycle;
      end
      if (EvtDone) begin
        done_cnt++;
        cap_crc = CrcErr;
        cap_seq = SeqErr;
        cap_cnt = EvtCnt;
      end
      if (FrameErr) ferr_cnt++;
    end
  end

  task automatic add_bits(input logic [11:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frame_bits.push_back(v[i]);
  endtask

  task automatic add_word(input logic [11:0] w, input logic [1:0] t);
    add_bits(w, 12);
    pend_q.push_back('{end_idx: frame_bits.size() - 1, w: w, t: t});
  endtask

  // Remainder of message * x^6 divided by x^6+x+1.
  function automatic logic [5:0] crc_div();
    logic [6:0] r;
    r = 7'd0;
    for (int i = 0; i < frame_bits.size() + 6; i++) begin
      r = {r[5:0], (i < frame_bits.size()) ? logic'(frame_bits[i]) : 1'b0};
      if (r[6]) r = r ^ 7'b1000011;
    end
    return r[5:0];
  endfunction

  task automatic build_frame(input logic [3:0] addr, input logic [4:0] evt, input logic [3:0] nchips,
                             input logic [5:0][4:0] nclus, input bit flip);
    logic [5:0] crc;
    int         idx;
    frame_bits.delete();
    pend_q.delete();
    add_bits(12'b10, 2);
    add_bits({8'd0, addr}, 4);
    add_word({evt, 2'b10, 1'b0, nchips}, 2'd0);
    for (int c = 0; c < int'(nchips); c++) begin
      add_word({1'b1, nclus[c], 2'b01, 4'(c)}, 2'd1);
      for (int k = 0; k < int'(nclus[c]); k++)
        add_word(12'h5A3 ^ 12'(c * 37 + k * 11), 2'd2);
    end
    crc = crc_div();
    if (flip) begin
      idx = frame_bits.size() - 1;
      frame_bits[idx] = ~frame_bits[idx];
      pend_q[pend_q.size() - 1].w[0] = ~pend_q[pend_q.size() - 1].w[0];
    end
    add_bits({6'd0, crc}, 6);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      DataIn = frame_bits[i];
      while (pend_q.size() > 0 && pend_q[0].end_idx == i) begin
        sb_q.push_back('{w: pend_q[0].w, t: pend_q[0].t});
        void'(pend_q.pop_front());
      end
    end
    @(negedge Clock);
    DataIn = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, " WordOut"}, WordOut, 0);
    checkOutput({tag, " WordType"}, WordType, 0);
    checkOutput({tag, " WordValid"}, WordValid, 0);
    checkOutput({tag, " BrdAddr"}, BrdAddr, 0);
    checkOutput({tag, " EvtDone"}, EvtDone, 0);
    checkOutput({tag, " CrcErr"}, CrcErr, 0);
    checkOutput({tag, " FrameErr"}, FrameErr, 0);
    checkOutput({tag, " SeqErr"}, SeqErr, 0);
    checkOutput({tag, " EvtCnt"}, EvtCnt, 0);
  endtask

  // Malformed-frame preambles: each must give exactly one FrameErr and no EvtDone.
  task automatic run_err(input int kind);
    int d0, f0, n;
    d0 = done_cnt;
    f0 = ferr_cnt;
    last_word_cycle = -1;
    case (kind)
      1: begin frame_bits.delete(); pend_q.delete(); add_bits(12'b11, 2); n = 2; end
      2: begin build_frame(4'h3, 5'd20, 4'd7, '0, 1'b0); pend_q.delete(); n = 18; end
      3: begin build_frame(4'h3, 5'd21, 4'd1, '0, 1'b0); void'(pend_q.pop_back()); n = 30; end
      default: begin build_frame(4'h5, 5'd22, 4'd0, '0, 1'b0); n = 6; end
    endcase
    send_bits(n);
    for (int i = 0; i < 20 && ferr_cnt == f0; i++) @(negedge Clock);
    repeat (3) @(negedge Clock);
    checkOutput($sformatf("frameerr strobes kind%0d", kind), ferr_cnt - f0, 1);
    checkOutput($sformatf("no evtdone on err kind%0d", kind), done_cnt - d0, 0);
    checkOutput($sformatf("evtcnt held kind%0d", kind), EvtCnt, exp_evtcnt);
    checkOutput($sformatf("words left kind%0d", kind), sb_q.size(), 0);
  endtask

  // Reset dropped in the middle of a cluster word.
  task automatic run_reset_midframe();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    last_word_cycle = -1;
    build_frame(4'h3, 5'd12, 4'd1, {25'd0, 5'd3}, 1'b0);
    send_bits(35);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    check_all_zero("midreset");
    checkOutput("midreset words left", sb_q.size(), 0);
    checkOutput("midreset no strobes", (done_cnt - d0) + (ferr_cnt - f0), 0);
    Reset = 1'b1;
    exp_evtcnt = 16'd0;
    repeat (2) @(negedge Clock);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int   d0, f0;
    logic exp_seq;
    case (v.pre)
      1, 2, 3, 4: run_err(v.pre);
      5: run_reset_midframe();
      6: begin
        @(negedge Clock); Reset = 1'b0;
        repeat (2) @(negedge Clock); Reset = 1'b1;
        exp_evtcnt = 16'd0;
        @(negedge Clock);
      end
      default: ;
    endcase
    d0 = done_cnt;
    f0 = ferr_cnt;
    last_word_cycle = -1;
    build_frame(v.addr, v.evt, v.nchips, v.nclus, v.flip);
    send_bits(frame_bits.size());
    for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge Clock);
    repeat (3) @(negedge Clock);
    exp_evtcnt = exp_evtcnt + 16'd1;
`ifdef MERGE_RX_SEQCHK_EN
    exp_seq = v.exp_seq;
`else
    exp_seq = 1'b0;
`endif
    checkOutput($sformatf("v%0d evtdone count", idx), done_cnt - d0, 1);
    checkOutput($sformatf("v%0d crcerr", idx), cap_crc, v.exp_crc);
    checkOutput($sformatf("v%0d seqerr", idx), cap_seq, exp_seq);
    checkOutput($sformatf("v%0d evtcnt", idx), cap_cnt, exp_evtcnt);
    checkOutput($sformatf("v%0d brdaddr", idx), BrdAddr, v.addr);
    checkOutput($sformatf("v%0d words left", idx), sb_q.size(), 0);
    checkOutput($sformatf("v%0d no frameerr", idx), ferr_cnt - f0, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs.push_back('{pre: 0, addr: 4'h3, evt: 5'd0,  nchips: 4'd0, nclus: '0, flip: 0, exp_crc: 0, exp_seq: 0});
    vecs.push_back('{pre: 0, addr: 4'h3, evt: 5'd1,  nchips: 4'd2, nclus: {20'd0, 5'd3, 5'd1}, flip: 0, exp_crc: 0, exp_seq: 0});
    vecs.push_back('{pre: 0, addr: 4'h3, evt: 5'd2,  nchips: 4'd2, nclus: {20'd0, 5'd3, 5'd1}, flip: 1, exp_crc: 1, exp_seq: 0});
    vecs.push_back('{pre: 0, addr: 4'h3, evt: 5'd2,  nchips: 4'd1, nclus: {25'd0, 5'd2}, flip: 0, exp_crc: 0, exp_seq: 0});
    vecs.push_back('{pre: 1, addr: 4'h3, evt: 5'd3,  nchips: 4'd1, nclus: {25'd0, 5'd1}, flip: 0, exp_crc: 0, exp_seq: 0});
    vecs.push_back('{pre: 2, addr: 4'h3, evt: 5'd4,  nchips: 4'd6, nclus: {5'd2, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1}, flip: 0, exp_crc: 0, exp_seq: 0});
    vecs.push_back('{pre: 3, addr: 4'h3, evt: 5'd5,  nchips: 4'd1, nclus: {25'd0, 5'd31}, flip: 0, exp_crc: 0, exp_seq: 0});
    vecs.push_back('{pre: 4, addr: 4'h3, evt: 5'd6,  nchips: 4'd0, nclus: '0, flip: 0, exp_crc: 0, exp_seq: 0});
    vecs.push_back('{pre: 0, addr: 4'h3, evt: 5'd9,  nchips: 4'd1, nclus: {25'd0, 5'd1}, flip: 0, exp_crc: 0, exp_seq: 1});
    vecs.push_back('{pre: 5, addr: 4'h3, evt: 5'd4,  nchips: 4'd2, nclus: {20'd0, 5'd1, 5'd1}, flip: 0, exp_crc: 0, exp_seq: 0});
    vecs.push_back('{pre: 0, addr: 4'h3, evt: 5'd5,  nchips: 4'd1, nclus: {25'd0, 5'd1}, flip: 0, exp_crc: 0, exp_seq: 0});
    vecs.push_back('{pre: 0, addr: 4'h3, evt: 5'd7,  nchips: 4'd1, nclus: {25'd0, 5'd2}, flip: 0, exp_crc: 0, exp_seq: 1});
    vecs.push_back('{pre: 6, addr: 4'h3, evt: 5'd31, nchips: 4'd1, nclus: {25'd0, 5'd1}, flip: 0, exp_crc: 0, exp_seq: 0});
    vecs.push_back('{pre: 0, addr: 4'h3, evt: 5'd0,  nchips: 4'd1, nclus: {25'd0, 5'd1}, flip: 0, exp_crc: 0, exp_seq: 0});

    Reset = 1'b0;
    DataIn = 1'b0;
    repeat (3) @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
